// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and small helpers for the traffic-light
// safety monitor.
package traffic_pkg;

    typedef logic [2:0] lamp_t;
    typedef logic [2:0] fault_code_t;

    localparam lamp_t RED    = 3'b100;
    localparam lamp_t YELLOW = 3'b010;
    localparam lamp_t GREEN  = 3'b001;

    localparam fault_code_t FLT_NONE         = 3'd0;
    localparam fault_code_t FLT_INVALID      = 3'd1;
    localparam fault_code_t FLT_CONFLICT     = 3'd2;
    localparam fault_code_t FLT_SKIP_YELLOW  = 3'd3;
    localparam fault_code_t FLT_BAD_ORDER    = 3'd4;
    localparam fault_code_t FLT_SHORT_YELLOW = 3'd5;
    localparam fault_code_t FLT_SHORT_ALLRED = 3'd6;

    // Wide enough for the 0..15 range of both minimum-time parameters.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic invalid;
        logic skipped_yellow;
        logic bad_order;
        logic short_yellow;
        logic enter_green;
    } road_check_t;

    function automatic logic lamp_valid(input lamp_t code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] max);
        return (cnt >= max) ? max : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp-code observation bus plus the monitor's fault outputs toward the
// lamp drivers.
interface traffic_conflict_monitor_if;
    import traffic_pkg::*;

    lamp_t       highway;
    lamp_t       country_road;
    logic        fault;
    fault_code_t fault_code;
    logic        flash_red;

    modport master (
        output highway,
        output country_road,
        input  fault,
        input  fault_code,
        input  flash_red
    );

    modport slave (
        input  highway,
        input  country_road,
        output fault,
        output fault_code,
        output flash_red
    );

endinterface

// File: rtl/lamp_seq_checker.sv
// Per-road sequencing checks: code validity, G->Y->R->G ordering and the
// minimum yellow time; also flags a legal R->G step for the all-red check.
module lamp_seq_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  lamp_t       cur,
    input  lamp_t       prev,
    input  logic        prev_valid,
    output road_check_t chk
);

    localparam logic [CNT_W-1:0] YEL_MAX = CNT_W'(MIN_YELLOW);

    logic [CNT_W-1:0] yel_cnt_q;
    logic [CNT_W-1:0] yel_cnt_d;

    // A zero count means the previous sample was not yellow, so this is entry.
    always_comb begin
        yel_cnt_d = '0;
        if (cur == YELLOW) begin
            yel_cnt_d = (yel_cnt_q == '0) ? CNT_W'(1) : sat_inc(yel_cnt_q, YEL_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            yel_cnt_q <= '0;
        end else begin
            yel_cnt_q <= yel_cnt_d;
        end
    end

    always_comb begin
        chk         = '0;
        chk.invalid = !lamp_valid(cur);
        if (prev_valid) begin
            chk.skipped_yellow = (prev == GREEN) && (cur == RED);
            chk.bad_order      = ((prev == RED) && (cur == YELLOW)) ||
                                 ((prev == YELLOW) && (cur == GREEN));
            chk.short_yellow   = (prev == YELLOW) && (cur == RED) && (yel_cnt_q < YEL_MAX);
            chk.enter_green    = (prev == RED) && (cur == GREEN);
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Passive safety monitor on the two lamp codes: latches the first violation
// and drives a flashing-red enable toward the lamp drivers.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 1,
    parameter int MIN_ALLRED = 1,
    parameter int FLASH_DIV  = 4
) (
    input  logic                        clk,
    input  logic                        clear,
    traffic_conflict_monitor_if.slave   bus
);

    localparam int                 DIV_W      = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FLASH_DIV - 1);
    localparam logic [CNT_W-1:0]   ALLRED_MAX = CNT_W'(MIN_ALLRED);

    lamp_t            cur_hw_q,  cur_hw_d;
    lamp_t            cur_cr_q,  cur_cr_d;
    lamp_t            prev_hw_q, prev_hw_d;
    lamp_t            prev_cr_q, prev_cr_d;
    logic             prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0] allred_cnt_q, allred_cnt_d;
    logic             fault_q, fault_d;
    fault_code_t      fault_code_q, fault_code_d;
    logic             flash_red_q, flash_red_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    road_check_t      hw_chk;
    road_check_t      cr_chk;
    logic             both_red;
    logic             conflict;
    logic             short_allred;
    fault_code_t      violation;

    // ---- stage 1: sample both lamp codes ----
    always_comb begin
        cur_hw_d     = bus.highway;
        cur_cr_d     = bus.country_road;
        prev_hw_d    = cur_hw_q;
        prev_cr_d    = cur_cr_q;
        prev_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        cur_hw_q  <= cur_hw_d;
        cur_cr_q  <= cur_cr_d;
        prev_hw_q <= prev_hw_d;
        prev_cr_q <= prev_cr_d;
    end

    // ---- stage 2: combinational checks on the registered samples ----
    lamp_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_hw_chk (
        .clk        (clk),
        .clear      (clear),
        .cur        (cur_hw_q),
        .prev       (prev_hw_q),
        .prev_valid (prev_valid_q),
        .chk        (hw_chk)
    );

    lamp_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_cr_chk (
        .clk        (clk),
        .clear      (clear),
        .cur        (cur_cr_q),
        .prev       (prev_cr_q),
        .prev_valid (prev_valid_q),
        .chk        (cr_chk)
    );

    always_comb begin
        both_red     = (cur_hw_q == RED) && (cur_cr_q == RED);
        conflict     = (cur_hw_q != RED) && (cur_cr_q != RED);
        allred_cnt_d = both_red ? sat_inc(allred_cnt_q, ALLRED_MAX) : '0;
        short_allred = (hw_chk.enter_green || cr_chk.enter_green) &&
                       (allred_cnt_q < ALLRED_MAX);
    end

    always_comb begin
        violation = FLT_NONE;
        if (hw_chk.invalid || cr_chk.invalid) begin
            violation = FLT_INVALID;
        end else if (conflict) begin
            violation = FLT_CONFLICT;
        end else if (hw_chk.skipped_yellow || cr_chk.skipped_yellow) begin
            violation = FLT_SKIP_YELLOW;
        end else if (hw_chk.bad_order || cr_chk.bad_order) begin
            violation = FLT_BAD_ORDER;
        end else if (hw_chk.short_yellow || cr_chk.short_yellow) begin
            violation = FLT_SHORT_YELLOW;
        end else if (short_allred) begin
            violation = FLT_SHORT_ALLRED;
        end
    end

    // ---- fault latch and flash divider ----
    always_comb begin
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (!fault_q && (violation != FLT_NONE)) begin
            fault_d      = 1'b1;
            fault_code_d = violation;
        end
    end

    // Flash starts lit on the fault edge and toggles every FLASH_DIV edges.
    always_comb begin
        flash_red_d = flash_red_q;
        div_cnt_d   = div_cnt_q;
        if (!fault_q) begin
            flash_red_d = fault_d;
            div_cnt_d   = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            flash_red_d = !flash_red_q;
            div_cnt_d   = '0;
        end else begin
            div_cnt_d   = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            prev_valid_q <= 1'b0;
            allred_cnt_q <= ALLRED_MAX;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            flash_red_q  <= 1'b0;
            div_cnt_q    <= '0;
        end else begin
            prev_valid_q <= prev_valid_d;
            allred_cnt_q <= allred_cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            flash_red_q  <= flash_red_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
    assign bus.flash_red  = flash_red_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: three parameterisations driven by the
// same lamp sequence, compared against a history-based reference model.
module tb_traffic_conflict_monitor;
    import traffic_pkg::*;

    localparam int ND = 3;

    int my_p[ND] = '{1, 3, 1};
    int ma_p[ND] = '{1, 1, 0};
    int fd_p[ND] = '{4, 3, 1};

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    traffic_conflict_monitor_if bus0();
    traffic_conflict_monitor_if bus1();
    traffic_conflict_monitor_if bus2();

    traffic_conflict_monitor #(.MIN_YELLOW(1), .MIN_ALLRED(1), .FLASH_DIV(4)) dut0 (
        .clk(clk), .clear(clear), .bus(bus0.slave));
    traffic_conflict_monitor #(.MIN_YELLOW(3), .MIN_ALLRED(1), .FLASH_DIV(3)) dut1 (
        .clk(clk), .clear(clear), .bus(bus1.slave));
    traffic_conflict_monitor #(.MIN_YELLOW(1), .MIN_ALLRED(0), .FLASH_DIV(1)) dut2 (
        .clk(clk), .clear(clear), .bus(bus2.slave));

    logic       d_fault[ND];
    logic [2:0] d_code[ND];
    logic       d_flash[ND];
    assign d_fault[0] = bus0.fault;  assign d_code[0] = bus0.fault_code;  assign d_flash[0] = bus0.flash_red;
    assign d_fault[1] = bus1.fault;  assign d_code[1] = bus1.fault_code;  assign d_flash[1] = bus1.flash_red;
    assign d_fault[2] = bus2.fault;  assign d_code[2] = bus2.fault_code;  assign d_flash[2] = bus2.flash_red;

    int vectors     = 0;
    int miscompares = 0;
    int checks      = 0;

    // Reference model: full lamp history since the last clear.
    logic [2:0] hq[$];
    logic [2:0] cq[$];
    logic       m_fault[ND];
    logic [2:0] m_code[ND];
    int         t_fault[ND];
    int         edge_cnt = 0;

    function automatic bit legal(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    // Consecutive yellow samples ending at the previous sample.
    function automatic int yel_run(input bit road);
        int k = 0;
        logic [2:0] v;
        for (int j = hq.size() - 2; j >= 0; j--) begin
            v = road ? cq[j] : hq[j];
            if (v != 3'b010) return k;
            k++;
        end
        return k;
    endfunction

    // Consecutive both-red samples ending at the previous sample; a run that
    // reaches back to the clear counts as unlimited.
    function automatic int allred_run();
        for (int j = hq.size() - 2; j >= 0; j--) begin
            if (!(hq[j] == 3'b100 && cq[j] == 3'b100)) return hq.size() - 2 - j;
        end
        return 1000;
    endfunction

    function automatic int rule_code(input int my, input int ma);
        int n;
        logic [2:0] ch, cc, ph, pc;
        n  = hq.size();
        ch = hq[n-1];
        cc = cq[n-1];
        if (!legal(ch) || !legal(cc)) return 1;
        if (ch != 3'b100 && cc != 3'b100) return 2;
        if (n < 2) return 0;
        ph = hq[n-2];
        pc = cq[n-2];
        if ((ph == 3'b001 && ch == 3'b100) || (pc == 3'b001 && cc == 3'b100)) return 3;
        if ((ph == 3'b100 && ch == 3'b010) || (ph == 3'b010 && ch == 3'b001) ||
            (pc == 3'b100 && cc == 3'b010) || (pc == 3'b010 && cc == 3'b001)) return 4;
        if ((ph == 3'b010 && ch == 3'b100 && yel_run(1'b0) < my) ||
            (pc == 3'b010 && cc == 3'b100 && yel_run(1'b1) < my)) return 5;
        if (((ph == 3'b100 && ch == 3'b001) || (pc == 3'b100 && cc == 3'b001)) &&
            allred_run() < ma) return 6;
        return 0;
    endfunction

    task automatic model_edge(input logic [2:0] hw, input logic [2:0] cr, input logic clr);
        int c;
        edge_cnt++;
        if (clr) begin
            for (int i = 0; i < ND; i++) begin
                m_fault[i] = 1'b0;
                m_code[i]  = 3'd0;
            end
            hq.delete();
            cq.delete();
        end else if (hq.size() > 0) begin
            for (int i = 0; i < ND; i++) begin
                c = rule_code(my_p[i], ma_p[i]);
                if (!m_fault[i] && c != 0) begin
                    m_fault[i] = 1'b1;
                    m_code[i]  = 3'(c);
                    t_fault[i] = edge_cnt;
                end
            end
        end
        hq.push_back(hw);
        cq.push_back(cr);
    endtask

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (vector %0d)", tag, got, exp, vectors);
        end
    endtask

    task automatic check_models();
        logic ef;
        for (int i = 0; i < ND; i++) begin
            ef = m_fault[i] ? ((((edge_cnt - t_fault[i]) / fd_p[i]) % 2) == 0) : 1'b0;
            chk($sformatf("m_fault%0d", i), {2'b00, d_fault[i]}, {2'b00, m_fault[i]});
            chk($sformatf("m_code%0d", i),  d_code[i], m_code[i]);
            chk($sformatf("m_flash%0d", i), {2'b00, d_flash[i]}, {2'b00, ef});
        end
    endtask

    task automatic step(input logic [2:0] hw, input logic [2:0] cr, input logic clr);
        clear             = clr;
        bus0.highway      = hw;  bus0.country_road = cr;
        bus1.highway      = hw;  bus1.country_road = cr;
        bus2.highway      = hw;  bus2.country_road = cr;
        @(posedge clk);
        model_edge(hw, cr, clr);
        vectors++;
        #1;
        check_models();
    endtask

    task automatic steps(input int n, input logic [2:0] hw, input logic [2:0] cr);
        for (int k = 0; k < n; k++) step(hw, cr, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at vector %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lamps[3];
        logic [2:0] leg_hw[7];
        logic [2:0] leg_cr[7];
        logic [2:0] hw, cr;
        logic       clr;
        lamps  = '{RED, YELLOW, GREEN};
        leg_hw = '{GREEN, YELLOW, RED, RED, RED, RED, GREEN};
        leg_cr = '{RED, RED, RED, GREEN, YELLOW, RED, RED};

        // Reset state
        step(RED, RED, 1'b1);
        step(RED, RED, 1'b1);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst_fault%0d", i), {2'b00, d_fault[i]}, 3'd0);
            chk($sformatf("rst_code%0d", i),  d_code[i], 3'd0);
            chk($sformatf("rst_flash%0d", i), {2'b00, d_flash[i]}, 3'd0);
        end

        // Legal cycle three times
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 7; s++) step(leg_hw[s], leg_cr[s], 1'b0);
        chk("legal_fault",  {2'b00, bus0.fault}, 3'd0);
        chk("legal_flash",  {2'b00, bus0.flash_red}, 3'd0);
        chk("legal_ar0",    {2'b00, bus2.fault}, 3'd0);
        chk("legal_y3code", bus1.fault_code, FLT_SHORT_YELLOW);

        // Conflict: edge N, then flash phases at N+1, N+5, N+9
        step(GREEN, GREEN, 1'b0);
        chk("conf_latency", {2'b00, bus0.fault}, 3'd0);
        step(GREEN, GREEN, 1'b0);
        chk("conf_fault", {2'b00, bus0.fault}, 3'd1);
        chk("conf_code",  bus0.fault_code, FLT_CONFLICT);
        chk("conf_fl1",   {2'b00, bus0.flash_red}, 3'd1);
        steps(4, GREEN, GREEN);
        chk("conf_fl5",   {2'b00, bus0.flash_red}, 3'd0);
        steps(4, GREEN, GREEN);
        chk("conf_fl9",   {2'b00, bus0.flash_red}, 3'd1);

        // Clear mid-fault; green as first post-clear sample is legal
        step(YELLOW, RED, 1'b0);
        step(GREEN, RED, 1'b1);
        chk("clr_fault", {2'b00, bus0.fault}, 3'd0);
        chk("clr_code",  bus0.fault_code, 3'd0);
        chk("clr_flash", {2'b00, bus0.flash_red}, 3'd0);
        steps(3, GREEN, RED);
        chk("clr_green0", {2'b00, bus0.fault}, 3'd0);
        chk("clr_green1", {2'b00, bus1.fault}, 3'd0);

        // Skipped yellow
        steps(2, RED, RED);
        chk("skip_code0", bus0.fault_code, FLT_SKIP_YELLOW);
        chk("skip_code1", bus1.fault_code, FLT_SKIP_YELLOW);

        // Short yellow with MIN_YELLOW=3, then exactly three yellows
        step(GREEN, RED, 1'b1);
        step(GREEN, RED, 1'b0);
        steps(2, YELLOW, RED);
        steps(2, RED, RED);
        chk("shorty_code1",  bus1.fault_code, FLT_SHORT_YELLOW);
        chk("shorty_fault0", {2'b00, bus0.fault}, 3'd0);
        step(GREEN, RED, 1'b1);
        step(GREEN, RED, 1'b0);
        steps(3, YELLOW, RED);
        steps(2, RED, RED);
        chk("y3_exact", {2'b00, bus1.fault}, 3'd0);

        // Invalid and conflict together, then a later conflict
        step(RED, RED, 1'b1);
        step(RED, RED, 1'b0);
        step(3'b011, GREEN, 1'b0);
        step(GREEN, GREEN, 1'b0);
        chk("inv_code", bus0.fault_code, FLT_INVALID);
        step(GREEN, GREEN, 1'b0);
        chk("inv_hold", bus0.fault_code, FLT_INVALID);

        // Short all-red: HW Y->R with CR R->G in one sample
        step(GREEN, RED, 1'b1);
        step(GREEN, RED, 1'b0);
        step(YELLOW, RED, 1'b0);
        steps(2, RED, GREEN);
        chk("ar_code0", bus0.fault_code, FLT_SHORT_ALLRED);
        chk("ar_code1", bus1.fault_code, FLT_SHORT_YELLOW);
        chk("ar_zero",  {2'b00, bus2.fault}, 3'd0);

        // Bad order R->Y and Y->G
        step(RED, RED, 1'b1);
        step(RED, RED, 1'b0);
        steps(2, YELLOW, RED);
        chk("ord_ry", bus0.fault_code, FLT_BAD_ORDER);
        step(GREEN, RED, 1'b1);
        step(GREEN, RED, 1'b0);
        step(YELLOW, RED, 1'b0);
        steps(2, GREEN, RED);
        chk("ord_yg", bus0.fault_code, FLT_BAD_ORDER);

        // Randomised phase against the model
        hw = GREEN;
        cr = RED;
        for (int s = 0; s < 1200; s++) begin
            clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) >= 65)
                hw = ($urandom_range(0, 99) < 90) ? lamps[$urandom_range(0, 2)] : 3'($urandom);
            if ($urandom_range(0, 99) >= 65)
                cr = ($urandom_range(0, 99) < 90) ? lamps[$urandom_range(0, 2)] : 3'($urandom);
            if (hw != RED && cr != RED && $urandom_range(0, 99) < 80) cr = RED;
            step(hw, cr, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
